// File: rtl/decoder_3to8.sv
// decoder_3to8: registered 3-to-8 line decoder with active-high enable.
// The select {A,B,C} (A is the MSB) picks one of eight enable lines Y7..Y0.
// The decode is captured on the rising clock edge, so downstream logic only
// ever sees clean one-hot or all-zero patterns, never an intermediate mix.
module decoder_3to8 (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic en,
    output logic Y0,
    output logic Y1,
    output logic Y2,
    output logic Y3,
    output logic Y4,
    output logic Y5,
    output logic Y6,
    output logic Y7
);

    logic [2:0] sel;
    logic [7:0] oneHot_d;
    logic [7:0] oneHot_q;

    assign sel = {A, B, C};

    // Next-state decode; the select is only examined when enabled so an unknown select cannot leak out while disabled
    always_comb begin
        oneHot_d = 8'h00;
        if (en) begin
            oneHot_d = 8'h01 << sel;
        end
    end

    // Capture the decode each edge; reset wins over everything and clears all lines
    always_ff @(posedge clk) begin
        if (rst) begin
            oneHot_q <= 8'h00;
        end else begin
            oneHot_q <= oneHot_d;
        end
    end

    assign Y0 = oneHot_q[0];
    assign Y1 = oneHot_q[1];
    assign Y2 = oneHot_q[2];
    assign Y3 = oneHot_q[3];
    assign Y4 = oneHot_q[4];
    assign Y5 = oneHot_q[5];
    assign Y6 = oneHot_q[6];
    assign Y7 = oneHot_q[7];

endmodule

// File: tb/tb_decoder_3to8.sv
// tb_decoder_3to8: table-driven bench for the registered 3-to-8 decoder.
// Each table row gives the inputs presented before an edge and the Y7..Y0
// pattern expected just after that edge; a few hand-written sequences cover
// multi-cycle behaviour (enable drop/restore, reset priority, hold).
module tb_decoder_3to8;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] sel;
        logic [7:0] expY;
        string      name;
    } vec_t;

    logic clk;
    logic rst;
    logic A;
    logic B;
    logic C;
    logic en;
    logic Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;

    int checks;
    int errors;

    vec_t vecs[$];

    decoder_3to8 dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C   (C),
        .en  (en),
        .Y0  (Y0),
        .Y1  (Y1),
        .Y2  (Y2),
        .Y3  (Y3),
        .Y4  (Y4),
        .Y5  (Y5),
        .Y6  (Y6),
        .Y7  (Y7)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends even if something stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive inputs on the falling edge, then wait until just after the next rising edge
    task automatic applyStimulus(input logic r, input logic e, input logic [2:0] s);
        @(negedge clk);
        rst = r;
        en  = e;
        {A, B, C} = s;
        @(posedge clk);
        #1;
    endtask

    // Compare the current output pattern against the expected one
    task automatic checkOutput(input string name, input logic [7:0] expY);
        logic [7:0] actY;
        actY = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};
        checks++;
        if (actY !== expY) begin
            errors++;
            $display("[TB] FAIL %s: got Y=8'h%02h, required 8'h%02h", name, actY, expY);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en  = 1'b0;
        {A, B, C} = 3'b000;

        // reset held two cycles with a live decode request behind it
        vecs.push_back('{1'b1, 1'b1, 3'b111, 8'h00, "reset_cycle1"});
        vecs.push_back('{1'b1, 1'b1, 3'b111, 8'h00, "reset_cycle2"});
        vecs.push_back('{1'b0, 1'b1, 3'b111, 8'h80, "reset_release_sel7"});
        // disabled then enabled
        vecs.push_back('{1'b0, 1'b0, 3'b000, 8'h00, "disabled_sel0"});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 8'h01, "enable_sel0"});
        // sweep of even selects
        vecs.push_back('{1'b0, 1'b1, 3'b010, 8'h04, "sweep_sel2"});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 8'h10, "sweep_sel4"});
        vecs.push_back('{1'b0, 1'b1, 3'b110, 8'h40, "sweep_sel6"});
        // full decode in order
        vecs.push_back('{1'b0, 1'b1, 3'b000, 8'h01, "full_sel0"});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 8'h02, "full_sel1"});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 8'h04, "full_sel2"});
        vecs.push_back('{1'b0, 1'b1, 3'b011, 8'h08, "full_sel3"});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 8'h10, "full_sel4_A_is_msb"});
        vecs.push_back('{1'b0, 1'b1, 3'b101, 8'h20, "full_sel5"});
        vecs.push_back('{1'b0, 1'b1, 3'b110, 8'h40, "full_sel6"});
        vecs.push_back('{1'b0, 1'b1, 3'b111, 8'h80, "full_sel7"});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 8'h02, "full_sel1_lsb_is_c"});
        // disabled with a non-zero select
        vecs.push_back('{1'b0, 1'b0, 3'b101, 8'h00, "disabled_sel5"});
        vecs.push_back('{1'b0, 1'b0, 3'b111, 8'h00, "disabled_sel7"});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].sel);
            checkOutput(vecs[i].name, vecs[i].expY);
        end

        // enable drop mid-stream and restore
        applyStimulus(1'b0, 1'b1, 3'b110);
        checkOutput("endrop_before", 8'h40);
        applyStimulus(1'b0, 1'b0, 3'b110);
        checkOutput("endrop_low", 8'h00);
        applyStimulus(1'b0, 1'b1, 3'b110);
        checkOutput("endrop_restore", 8'h40);

        // reset priority over an active decode
        applyStimulus(1'b0, 1'b1, 3'b011);
        checkOutput("rstprio_before", 8'h08);
        applyStimulus(1'b1, 1'b1, 3'b011);
        checkOutput("rstprio_asserted", 8'h00);
        applyStimulus(1'b0, 1'b1, 3'b011);
        checkOutput("rstprio_released", 8'h08);

        // output holds between edges even when inputs change mid-cycle
        applyStimulus(1'b0, 1'b1, 3'b101);
        checkOutput("hold_after_edge", 8'h20);
        {A, B, C} = 3'b010;
        en = 1'b0;
        #3;
        checkOutput("hold_mid_cycle", 8'h20);
        @(posedge clk);
        #1;
        checkOutput("hold_next_edge_disabled", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
